fifo_ctrl: RTL

Sequencing and arbitration controller for the 8-entry FIFO register file. Each cycle it accepts one write request and one read request, decides which single operation the shared register file performs, and owns the head, tail and count registers. It drives the register-file enables and addresses and reports per-request ack/error status back to the requesters. It sits between the producer/consumer interfaces and the FIFO storage array.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/fifo_ctrl_if.sv | 33 +++
 rtl/fifo_ctrl_calc.sv | 41 ++++
 rtl/fifo_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO sequencing controller: sizes, FSM state
// encodings and the arbitration grant encoding.
package fifo_pkg;

  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  // Occupancy value that means "every entry holds data"
  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100
  } state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // True when the occupancy leaves no room for another write
  function automatic logic count_is_full(input cnt_t count);
    return count == FULL_COUNT;
  endfunction

  // True when the occupancy leaves nothing to read
  function automatic logic count_is_empty(input cnt_t count);
    return count == '0;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the producer/consumer side and the FIFO
// controller. The controller is the slave; requesters use the master view.
interface fifo_ctrl_if;
  import fifo_pkg::*;

  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  ptr_t       head;
  ptr_t       tail;
  cnt_t       data_count;
  logic       we;
  logic       re;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  modport master (
    output wr_en, rd_en,
    input  state, head, tail, data_count, we, re, full, empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, rd_en,
    output state, head, tail, data_count, we, re, full, empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_ctrl_calc.sv
// Combinational post-operation calculator: given the operation being
// performed this cycle, produce the pointer/count values that the registers
// load at the next edge, plus the register-file enables.
module fifo_ctrl_calc
  import fifo_pkg::*;
(
  input  state_e state,
  input  ptr_t   head,
  input  ptr_t   tail,
  input  cnt_t   data_count,
  output ptr_t   next_head,
  output ptr_t   next_tail,
  output cnt_t   next_data_count,
  output logic   we,
  output logic   re
);

  // Advance the pointer of the active operation; pointers wrap naturally
  // because DEPTH is a power of two. Error and idle states hold everything.
  always_comb begin
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    we              = 1'b0;
    re              = 1'b0;
    case (state)
      WRITE: begin
        next_tail       = tail + ptr_t'(1);
        next_data_count = data_count + cnt_t'(1);
        we              = 1'b1;
      end
      READ: begin
        next_head       = head + ptr_t'(1);
        next_data_count = data_count - cnt_t'(1);
        re              = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO sequencing and arbitration controller. Each cycle picks a single
// register-file operation from the write/read requests, owns head, tail and
// occupancy, and reports ack/error status one cycle after the request.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  fifo_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  ptr_t   head_q, tail_q;
  cnt_t   count_q;
  logic   wr_ack_q, wr_ack_d;
  logic   wr_err_q, wr_err_d;
  logic   rd_ack_q, rd_ack_d;
  logic   rd_err_q, rd_err_d;

  ptr_t   next_head, next_tail;
  cnt_t   next_count;
  logic   calc_we, calc_re;

  fifo_ctrl_calc u_calc (
    .state           (state_q),
    .head            (head_q),
    .tail            (tail_q),
    .data_count      (count_q),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_count),
    .we              (calc_we),
    .re              (calc_re)
  );

  // Choose the next operation against the post-op count so back-to-back
  // requests see the in-flight operation; ties at the extremes are forced,
  // otherwise they alternate using the last granted direction.
  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    case ({bus.wr_en, bus.rd_en})
      2'b10: state_d = count_is_full(next_count) ? WR_ERROR : WRITE;
      2'b01: state_d = count_is_empty(next_count) ? RD_ERROR : READ;
      2'b11: begin
        if (count_is_full(next_count)) begin
          state_d = READ;
        end else if (count_is_empty(next_count)) begin
          state_d = WRITE;
        end else if (last_grant_q == GRANT_RD) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == WRITE) begin
      last_grant_d = GRANT_WR;
    end else if (state_d == READ) begin
      last_grant_d = GRANT_RD;
    end
    wr_ack_d = (state_d == WRITE);
    wr_err_d = (state_d == WR_ERROR);
    rd_ack_d = (state_d == READ);
    rd_err_d = (state_d == RD_ERROR);
  end

  // FSM, grant history, pointer/count and status registers; reset discards
  // whatever operation is in flight so no pointer advances.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      head_q       <= next_head;
      tail_q       <= next_tail;
      count_q      <= next_count;
      wr_ack_q     <= wr_ack_d;
      wr_err_q     <= wr_err_d;
      rd_ack_q     <= rd_ack_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.head       = head_q;
  assign bus.tail       = tail_q;
  assign bus.data_count = count_q;
  assign bus.we         = calc_we;
  assign bus.re         = calc_re;
  assign bus.full       = count_is_full(count_q);
  assign bus.empty      = count_is_empty(count_q);
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_err     = rd_err_q;

endmodule
